pipe_intr_sequencer: RTL and testbench

Interrupt entry/exit sequencer for the 5-stage pipelined CPU. It latches external interrupt edges, arbitrates them by fixed priority, and waits for a safe point in ID, meaning no branch, jump, mtc0 or hazard stall. At that point it flushes IF/ID and ID/EX, redirects the PC to the handler and saves EPC. On `eret` it returns to EPC and enforces a hold-off window before the next interrupt can be taken.

---
 rtl/pcpu_intr_pkg.sv | 23 ++
 rtl/intr_prio_enc.sv | 23 ++
 rtl/pipe_intr_sequencer.sv | 125 ++++++++++++
 tb/tb_pipe_intr_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_intr_pkg.sv
// Shared definitions for the pipelined CPU interrupt sequencer: state encoding,
// default vector layout and status register bit positions.
package pcpu_intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVICE = 2'd1,
        ST_HOLDOFF = 2'd2
    } intr_state_t;

    localparam logic [31:0] DEF_HANDLER_BASE = 32'h0000_0040;
    localparam int          DEF_VEC_STRIDE   = 8;

    localparam int STATUS_GIE_BIT  = 0;
    localparam int STATUS_MASK_LSB = 1;

    // Handler vector address, wrapping modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input int stride,
                                             input int idx);
        return base + (32'(idx) * 32'(stride));
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder over the eligible interrupt vector.
module intr_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_intr_sequencer.sv
// Interrupt entry/exit sequencer: captures IRQ edges, takes the highest priority
// request at a safe point in ID, and handles eret return plus a hold-off window.
module pipe_intr_sequencer
    import pcpu_intr_pkg::*;
#(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] HANDLER_BASE = DEF_HANDLER_BASE,
    parameter int          VEC_STRIDE   = DEF_VEC_STRIDE,
    parameter int          HOLD_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               status_we,
    input  logic [NUM_IRQ:0]   status_wdata,
    input  logic               eret,
    input  logic               id_ctrl_busy,
    input  logic               pipe_stall,
    input  logic [31:0]        id_pc,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               pc_sel,
    output logic [31:0]        pc_target,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [31:0]        epc,
    output logic [NUM_IRQ:0]   status,
    output logic               in_service,
    output logic [1:0]         state_dbg
);

    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    intr_state_t        state, state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic               gie;
    logic [3:0]         cnt;
    logic [ID_W-1:0]    id;
    logic               id_valid;
    logic               take;
    logic               do_ret;

    intr_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_prio (
        .req   (pending & mask),
        .id    (id),
        .valid (id_valid)
    );

    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        do_ret      = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = '0;
        irq_ack     = '0;
        case (state)
            ST_IDLE: begin
                if (gie && id_valid && !id_ctrl_busy && !pipe_stall) begin
                    take        = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    pc_sel      = 1'b1;
                    pc_target   = vec_addr(HANDLER_BASE, VEC_STRIDE, int'(id));
                    irq_ack     = NUM_IRQ'(1) << id;
                    state_nxt   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // Only ID/EX survives: eret itself is the instruction leaving ID.
                if (eret && !pipe_stall) begin
                    do_ret      = 1'b1;
                    flush_if_id = 1'b1;
                    pc_sel      = 1'b1;
                    pc_target   = epc;
                    state_nxt   = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt <= 4'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A new edge on the acked line in the same cycle keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~irq_ack) | (irq & ~irq_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gie  <= 1'b0;
            mask <= '0;
            epc  <= '0;
            cnt  <= '0;
        end else begin
            if (status_we) mask <= status_wdata[NUM_IRQ:STATUS_MASK_LSB];
            if (take)                gie <= 1'b0;
            else if (do_ret)         gie <= 1'b1;
            else if (status_we)      gie <= status_wdata[STATUS_GIE_BIT];
            if (take) epc <= id_pc;
            if (do_ret)                   cnt <= 4'(HOLD_CYCLES);
            else if (state == ST_HOLDOFF) cnt <= cnt - 4'd1;
        end
    end

    assign status     = {mask, gie};
    assign in_service = (state == ST_SERVICE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_pipe_intr_sequencer.sv
// Directed bench for pipe_intr_sequencer: entry, priority, safe-point wait,
// masking, return/hold-off and asynchronous reset.
module tb_pipe_intr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        status_we;
  logic [4:0]  status_wdata;
  logic        eret;
  logic        id_ctrl_busy;
  logic        pipe_stall;
  logic [31:0] id_pc;
  logic        flush_if_id, flush_id_ex, pc_sel, in_service;
  logic [31:0] pc_target, epc;
  logic [3:0]  irq_ack;
  logic [4:0]  status;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  pipe_intr_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .status_we(status_we), .status_wdata(status_wdata),
    .eret(eret), .id_ctrl_busy(id_ctrl_busy), .pipe_stall(pipe_stall), .id_pc(id_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_sel(pc_sel),
    .pc_target(pc_target), .irq_ack(irq_ack), .epc(epc), .status(status),
    .in_service(in_service), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq = '0; status_we = 0; status_wdata = '0; eret = 0;
    id_ctrl_busy = 0; pipe_stall = 0; id_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #12;
    total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL reset_pc_sel got=%b exp=0", pc_sel); end
    total++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin bad++; $display("FAIL reset_flush got=%b exp=00", {flush_if_id, flush_id_ex}); end
    total++; if (pc_target !== 32'h0 || irq_ack !== 4'h0) begin bad++; $display("FAIL reset_target_ack got=%h/%b exp=0/0000", pc_target, irq_ack); end
    total++; if (epc !== 32'h0 || status !== 5'h0 || in_service !== 1'b0) begin bad++; $display("FAIL reset_regs got=%h/%b/%b exp=0/00000/0", epc, status, in_service); end
    @(negedge clk);
    rst = 0;
    tick();
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic write_status(input logic [4:0] v);
    status_we = 1; status_wdata = v;
    tick();
    status_we = 0;
  endtask

  // eret with no stall, then run out the 2-cycle hold-off
  task automatic do_return(input logic [31:0] exp_epc, input string nm);
    eret = 1;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== exp_epc || flush_if_id !== 1'b1 || flush_id_ex !== 1'b0) begin
      bad++; $display("FAIL %s_eret got=%b/%h/%b%b exp=1/%h/10", nm, pc_sel, pc_target, flush_if_id, flush_id_ex, exp_epc); end
    tick();
    eret = 0;
    tick();
    tick();
  endtask

  task automatic test_single();
    write_status(5'b00011);
    irq = 4'b0001; id_pc = 32'h100;
    tick();
    irq = 4'b0000;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== 32'h40 || irq_ack !== 4'b0001) begin
      bad++; $display("FAIL single_take got=%b/%h/%b exp=1/00000040/0001", pc_sel, pc_target, irq_ack); end
    total++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin bad++; $display("FAIL single_flush got=%b exp=11", {flush_if_id, flush_id_ex}); end
    tick();
    id_pc = 32'h104;
    total++; if (epc !== 32'h100 || in_service !== 1'b1 || status !== 5'b00010) begin
      bad++; $display("FAIL single_after got=%h/%b/%b exp=100/1/00010", epc, in_service, status); end
    total++; if (irq_ack !== 4'b0000 || pc_sel !== 1'b0) begin bad++; $display("FAIL single_no_nest got=%b/%b exp=0000/0", irq_ack, pc_sel); end
    do_return(32'h100, "single");
    total++; if (status !== 5'b00011 || state_dbg !== 2'd0) begin bad++; $display("FAIL single_back got=%b/%0d exp=00011/0", status, state_dbg); end
  endtask

  task automatic test_priority();
    write_status(5'b11111);
    irq = 4'b0110; id_pc = 32'h300;
    tick();
    irq = 4'b0000;
    #1;
    total++; if (pc_target !== 32'h48 || irq_ack !== 4'b0010) begin
      bad++; $display("FAIL prio_first got=%h/%b exp=00000048/0010", pc_target, irq_ack); end
    tick();
    eret = 1;
    #1;
    total++; if (pc_target !== 32'h300) begin bad++; $display("FAIL prio_eret got=%h exp=00000300", pc_target); end
    tick();
    eret = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (pc_sel !== 1'b0 || irq_ack !== 4'b0000) begin bad++; $display("FAIL prio_holdoff%0d got=%b/%b exp=0/0000", i, pc_sel, irq_ack); end
      tick();
    end
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== 32'h50 || irq_ack !== 4'b0100) begin
      bad++; $display("FAIL prio_second got=%b/%h/%b exp=1/00000050/0100", pc_sel, pc_target, irq_ack); end
    tick();
    do_return(32'h300, "prio");
  endtask

  task automatic test_safe_point();
    id_ctrl_busy = 1;
    irq = 4'b1000; id_pc = 32'h400;
    tick();
    irq = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (pc_sel !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
        bad++; $display("FAIL safe_busy%0d got=%b%b%b exp=000", i, pc_sel, flush_if_id, flush_id_ex); end
      tick();
    end
    id_ctrl_busy = 0; pipe_stall = 1;
    #1;
    total++; if (pc_sel !== 1'b0 || flush_id_ex !== 1'b0) begin bad++; $display("FAIL safe_stall got=%b%b exp=00", pc_sel, flush_id_ex); end
    tick();
    pipe_stall = 0; id_pc = 32'h444;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== 32'h58 || irq_ack !== 4'b1000) begin
      bad++; $display("FAIL safe_take got=%b/%h/%b exp=1/00000058/1000", pc_sel, pc_target, irq_ack); end
    tick();
    total++; if (epc !== 32'h444) begin bad++; $display("FAIL safe_epc got=%h exp=00000444", epc); end
    eret = 1; pipe_stall = 1;
    #1;
    total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL safe_eret_stall got=%b exp=0", pc_sel); end
    tick();
    total++; if (in_service !== 1'b1) begin bad++; $display("FAIL safe_eret_wait got=%b exp=1", in_service); end
    pipe_stall = 0;
    do_return(32'h444, "safe");
  endtask

  task automatic test_masking();
    write_status(5'b01111);
    irq = 4'b1000; id_pc = 32'h200;
    tick();
    irq = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL mask_blocked%0d got=%b exp=0", i, pc_sel); end
      tick();
    end
    status_we = 1; status_wdata = 5'b11111;
    tick();
    status_we = 1; status_wdata = 5'b10001;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== 32'h58) begin bad++; $display("FAIL mask_take got=%b/%h exp=1/00000058", pc_sel, pc_target); end
    tick();
    status_we = 0;
    total++; if (status !== 5'b10000 || epc !== 32'h200) begin bad++; $display("FAIL mask_gie_override got=%b/%h exp=10000/200", status, epc); end
    status_we = 1; status_wdata = 5'b11110;
    eret = 1;
    #1;
    total++; if (pc_sel !== 1'b1 || pc_target !== 32'h200 || flush_if_id !== 1'b1) begin
      bad++; $display("FAIL ret_redirect got=%b/%h/%b exp=1/00000200/1", pc_sel, pc_target, flush_if_id); end
    tick();
    status_we = 0;
    total++; if (status !== 5'b11111 || state_dbg !== 2'd2) begin bad++; $display("FAIL ret_status got=%b/%0d exp=11111/2", status, state_dbg); end
    // eret during hold-off is ignored
    #1;
    total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL ret_holdoff_eret got=%b exp=0", pc_sel); end
    tick();
    eret = 0;
    tick();
    eret = 1;
    #1;
    total++; if (pc_sel !== 1'b0 || state_dbg !== 2'd0) begin bad++; $display("FAIL ret_idle_eret got=%b/%0d exp=0/0", pc_sel, state_dbg); end
    tick();
    eret = 0;
  endtask

  task automatic test_async_reset();
    irq = 4'b0011; id_pc = 32'h500;
    tick();
    irq = 4'b0000;
    tick();
    total++; if (in_service !== 1'b1 || epc !== 32'h500) begin bad++; $display("FAIL arst_setup got=%b/%h exp=1/500", in_service, epc); end
    #2;
    rst = 1;
    #1;
    total++; if (in_service !== 1'b0 || epc !== 32'h0 || status !== 5'h0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL arst_immediate got=%b/%h/%b/%0d exp=0/0/00000/0", in_service, epc, status, state_dbg); end
    @(negedge clk);
    rst = 0;
    tick();
    eret = 1;
    #1;
    total++; if (pc_sel !== 1'b0) begin bad++; $display("FAIL arst_eret got=%b exp=0", pc_sel); end
    tick();
    eret = 0;
    write_status(5'b11111);
    #1;
    total++; if (pc_sel !== 1'b0 || irq_ack !== 4'b0000) begin bad++; $display("FAIL arst_pending got=%b/%b exp=0/0000", pc_sel, irq_ack); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_safe_point();
    test_masking();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
